shift_sweep_sequencer: RTL
==========================

# shift_sweep_sequencer

Upstream control stage for the 8-bit left/right shift stage. It holds an operand and drives `a`, `amt` and `choice` into the shifter. On a prescaled tick it steps the shift amount 0→7, so the shifted pattern sweeps visibly on the board LEDs. It supports one-shot and continuous sweeps with start/stop/pause control and registered status pulses.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per sweep step; legal range ≥ 2.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `load`  in  1: capture `data_in` into the operand register.
- `data_in`  in  8: operand value.
- `start`  in  1: level-sampled; begin or resume a sweep.
- `stop`  in  1: level-sampled; pause, or abort when already paused.
- `dir_in`  in  1: initial direction on start from IDLE (0 = left, 1 = right).
- `mode`  in  1: 0 = one-shot sweep, 1 = continuous.
- `a`  out  8: operand to the shift stage.
- `amt`  out  3: shift amount to the shift stage.
- `choice`  out  1: direction to the shift stage (1 = right).
- `busy`  out  1: high in RUN and PAUSE.
- `step`  out  1: one-cycle pulse; coincident with each new `amt`/`choice` value.
- `done`  out  1: one-cycle pulse at the end of a one-shot sweep.

## Operation
- **States:** IDLE, RUN, PAUSE.
- **Input priority per cycle:** stop > start > load > tick.
- **IDLE:**
  - `load` → `a` ← `data_in`.
  - `start` (with `stop` low) → RUN; `amt` ← 0; `choice` ← `dir_in`; prescaler cleared.
- **RUN:**
  - `load` is ignored.
  - `stop` → PAUSE; `amt`, `choice` and the prescaler count are held.
  - On tick with `amt` < 7: `amt` ← `amt` + 1, `step` pulses.
  - On tick with `amt` == 7 and `mode` = 0: `amt` ← 0, `choice` held, `done` and `step` pulse, → IDLE.
  - On tick with `amt` == 7 and `mode` = 1: `amt` ← 0, `step` pulses, state stays RUN. `choice` follows the Configuration rule.
- **PAUSE:**
  - `load` → `a` ← `data_in`.
  - `start` (with `stop` low) → RUN; resumes with the held `amt`, `choice` and prescaler count.
  - `stop` → IDLE; `amt` ← 0, `choice` held.
- **Mid-sweep changes:** `mode` is sampled only at the `amt` == 7 tick. Changing `dir_in` mid-sweep has no effect.
- **Simultaneous events:**
  - `start` and `stop` both high → `stop` wins in every state.
  - `stop` high on a tick cycle in RUN → the tick is discarded, PAUSE is entered, and `amt` is unchanged.

## Timing
- All outputs are registered; there is no combinational input→output path.
- **Reset values:** `a` = 8'h00, `amt` = 0, `choice` = 0, `busy` = 0, `step` = 0, `done` = 0, state IDLE, prescaler 0.
- **Reset mid-sweep:** immediate return to all reset values; the operand is lost.
- **Start latency:** `busy` is high one cycle after `start` is sampled. The first `step` follows `TICK_DIV` cycles after that edge.
- **Tick:** fires when the prescaler equals `TICK_DIV`-1 in RUN; the prescaler then wraps to 0. A one-shot sweep is 8 ticks, i.e. 8·`TICK_DIV` cycles.
- **Load:** the new `a` is visible the cycle after `load` is sampled.
- **Done:** `done` and `busy` falling occur on the same edge.
- **Prescaler width:** `$clog2(TICK_DIV)` bits.

## Configuration
- **Macro:** `SHIFT_SWEEP_BOUNCE_EN`.
- **Defined:** in continuous mode, the `amt` == 7 tick also toggles `choice`, so the pattern alternates left and right sweeps.
- **Undefined:** `choice` never changes during RUN; continuous mode repeats the same direction.
- **One-shot mode:** identical in both builds.

## Structure
- **Package `shift_sweep_pkg`:**
  - state enum `sweep_state_t` {IDLE, RUN, PAUSE};
  - `DATA_W` = 8;
  - `AMT_W` = 3;
  - `AMT_MAX` = 3'd7.
- **Sub-module `tick_prescaler`:**
  - mod-`TICK_DIV` counter with `clr` and `en` inputs and a registered-free `tick` output.
  - `en` is high only in RUN; `clr` is driven on the IDLE→RUN transition.
- Top level holds the FSM, operand, `amt` and `choice` registers, and the pulse logic.

## Test plan
Scenarios use `TICK_DIV` = 4.
- **Reset:** assert `reset` mid-RUN with `amt` = 5 → all outputs 0 the same cycle, asynchronously; state IDLE.
- **One-shot sweep:** `load` 8'hA5, then `start` with `dir_in` = 1, `mode` = 0.
  - `amt` steps 1..7 every 4 cycles with `choice` = 1 and `step` pulsing.
  - On the 8th tick: `amt` = 0, `done` pulses once, `busy` falls; total 32 cycles.
- **Pause/resume:** `stop` when `amt` = 3 and the prescaler = 2.
  - `amt` holds at 3 while paused; `load` 8'h3C updates `a`.
  - `start` → next step to 4 after 2 cycles.
- **Abort:** `stop` in PAUSE → IDLE, `amt` = 0, `busy` = 0, no `done`.
- **Priority:** `start` and `stop` high together in IDLE → stays IDLE.
  - `load` in RUN → `a` unchanged.
  - `stop` on a tick cycle → `amt` unchanged.
- **Continuous mode:** `mode` = 1, `dir_in` = 0, run 16 ticks.
  - With `SHIFT_SWEEP_BOUNCE_EN`: `choice` = 0 for ticks 1–8, then 1 for ticks 9–16.
  - Without it: `choice` stays 0.
  - `done` never asserts in either build.

Source files
------------

// File: rtl/shift_sweep_pkg.sv
// Shared types and widths for the shift sweep sequencer and its shift-stage interface.
package shift_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sweep_state_t;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;
    localparam logic [AMT_W-1:0] AMT_MAX = 3'd7;

endpackage

// File: rtl/shift_sweep_sequencer_if.sv
// Control inputs and shift-stage outputs of the sweep sequencer, bundled as one interface.
interface shift_sweep_sequencer_if;
    import shift_sweep_pkg::*;

    logic              load;
    logic [DATA_W-1:0] data_in;
    logic              start;
    logic              stop;
    logic              dir_in;
    logic              mode;
    logic [DATA_W-1:0] a;
    logic [AMT_W-1:0]  amt;
    logic              choice;
    logic              busy;
    logic              step;
    logic              done;

    modport master (
        output load, data_in, start, stop, dir_in, mode,
        input  a, amt, choice, busy, step, done
    );

    modport slave (
        input  load, data_in, start, stop, dir_in, mode,
        output a, amt, choice, busy, step, done
    );

endinterface

// File: rtl/tick_prescaler.sv
// Mod-TICK_DIV step prescaler; tick is a decode of the count, asserted only while enabled.
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_sweep_sequencer.sv
// Steps the shift amount 0..7 on a prescaled tick with start/stop/pause control.
// Define SHIFT_SWEEP_BOUNCE_EN to flip direction at the end of each continuous sweep.
module shift_sweep_sequencer
    import shift_sweep_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    shift_sweep_sequencer_if.slave  bus
);

    sweep_state_t      state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic              choice_q, choice_d;
    logic              busy_q, busy_d;
    logic              step_q, step_d;
    logic              done_q, done_d;

    logic tick;
    logic pre_clr;
    logic pre_en;
    logic sweep_end;

    // Holding en low while stop is high both freezes the count and swallows a coincident tick.
    assign pre_en    = (state_q == RUN) && !bus.stop;
    assign pre_clr   = (state_q == IDLE) && bus.start && !bus.stop;
    assign sweep_end = tick && (amt_q == AMT_MAX);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!bus.stop && bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.stop)                       state_d = PAUSE;
                else if (sweep_end && !bus.mode)    state_d = IDLE;
            end
            PAUSE: begin
                if (bus.stop)       state_d = IDLE;
                else if (bus.start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        amt_d    = amt_q;
        choice_d = choice_q;
        step_d   = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (!bus.stop && bus.start) begin
                    amt_d    = '0;
                    choice_d = bus.dir_in;
                end else if (!bus.stop && bus.load) begin
                    a_d = bus.data_in;
                end
            end
            RUN: begin
                if (tick) begin
                    step_d = 1'b1;
                    if (amt_q == AMT_MAX) begin
                        amt_d = '0;
                        if (!bus.mode) begin
                            done_d = 1'b1;
                        end else begin
`ifdef SHIFT_SWEEP_BOUNCE_EN
                            choice_d = !choice_q;
`endif
                        end
                    end else begin
                        amt_d = amt_q + AMT_W'(1);
                    end
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    amt_d = '0;
                end else if (!bus.start && bus.load) begin
                    a_d = bus.data_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            amt_q    <= '0;
            choice_q <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            amt_q    <= amt_d;
            choice_q <= choice_d;
            busy_q   <= busy_d;
            step_q   <= step_d;
            done_q   <= done_d;
        end
    end

    assign bus.a      = a_q;
    assign bus.amt    = amt_q;
    assign bus.choice = choice_q;
    assign bus.busy   = busy_q;
    assign bus.step   = step_q;
    assign bus.done   = done_q;

endmodule
